// File: rtl/calc_sequencer.sv
// Operand/opcode entry sequencer for the calculator core: captures A, B and opcode on button
// edges, launches one start pulse, then latches the result or aborts on a timeout.
module calc_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] switches,
    input  logic             calc_ready,
    input  logic [WIDTH-1:0] calc_result,
    input  logic [5:0]       calc_flags,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [1:0]       op_code,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [5:0]       flags,
    output logic             done,
    output logic             timeout,
    output logic [2:0]       state
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StLoadA  = 3'd0,
        StLoadB  = 3'd1,
        StLoadOp = 3'd2,
        StGo     = 3'd3,
        StWait   = 3'd4,
        StDone   = 3'd5
    } state_e;

    state_e          state_q;
    logic            en_q;
    logic            en_edge;
    logic [CntW-1:0] cnt_q;

    // en_q resets high so a button held through reset release is not taken as an edge.
    assign en_edge = enable & ~en_q;
    assign state   = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StLoadA;
            en_q    <= 1'b1;
            cnt_q   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_code <= '0;
            start   <= 1'b0;
            busy    <= 1'b0;
            result  <= '0;
            flags   <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            en_q  <= enable;
            start <= 1'b0;
            case (state_q)
                StLoadA: begin
                    if (en_edge) begin
                        op_a    <= switches;
                        state_q <= StLoadB;
                    end
                end
                StLoadB: begin
                    if (en_edge) begin
                        op_b    <= switches;
                        state_q <= StLoadOp;
                    end
                end
                StLoadOp: begin
                    if (en_edge) begin
                        op_code <= switches[1:0];
                        start   <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= StGo;
                    end
                end
                StGo: begin
                    timeout <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A ready arriving on the last count still wins over the timeout.
                    if (calc_ready) begin
                        result  <= calc_result;
                        flags   <= calc_flags;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else if (cnt_q == CntLast) begin
                        timeout <= 1'b1;
                        result  <= '0;
                        flags   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (en_edge) begin
                        done    <= 1'b0;
                        state_q <= StLoadA;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StLoadA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer; expected results are queued at launch and checked at done.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] switches;
    logic        calc_ready;
    logic [15:0] calc_result;
    logic [5:0]  calc_flags;
    logic [15:0] op_a, op_b, result;
    logic [1:0]  op_code;
    logic        start, busy, done, timeout;
    logic [5:0]  flags;
    logic [2:0]  state;

    typedef struct packed {
        logic [15:0] res;
        logic [5:0]  fl;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   start_cnt = 0;
    int   cyc;

    calc_sequencer #(.WIDTH(16), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .switches    (switches),
        .calc_ready  (calc_ready),
        .calc_result (calc_result),
        .calc_flags  (calc_flags),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_code     (op_code),
        .start       (start),
        .busy        (busy),
        .result      (result),
        .flags       (flags),
        .done        (done),
        .timeout     (timeout),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start === 1'b1) start_cnt <= start_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [15:0] v);
        @(negedge clk);
        switches = v;
        enable   = 1'b1;
        @(negedge clk);
        enable   = 1'b0;
    endtask

    // Counts negedges until done, bounded; then compares against the oldest queued result.
    task automatic wait_done(output int n);
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("result", {16'd0, result}, {16'd0, e.res});
            chk("flags", {26'd0, flags}, {26'd0, e.fl});
            chk("timeout", {31'd0, timeout}, {31'd0, e.to});
            chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; switches = '0;
        calc_ready = 1'b0; calc_result = '0; calc_flags = '0;
        #12;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_op_a", {16'd0, op_a}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Normal flow
        press(16'h3C00);
        chk("a_state", {29'd0, state}, 32'd1);
        chk("a_op_a", {16'd0, op_a}, 32'h3C00);
        press(16'h4000);
        chk("b_state", {29'd0, state}, 32'd2);
        press(16'h0000);
        chk("go_state", {29'd0, state}, 32'd3);
        chk("go_start", {31'd0, start}, 32'd1);
        chk("go_busy", {31'd0, busy}, 32'd1);
        sb.push_back('{res: 16'h4200, fl: 6'd0, to: 1'b0});
        @(negedge clk);
        chk("wait_state", {29'd0, state}, 32'd4);
        chk("wait_start", {31'd0, start}, 32'd0);
        repeat (5) @(negedge clk);
        calc_ready = 1'b1; calc_result = 16'h4200; calc_flags = 6'd0;
        wait_done(cyc);
        chk("ready_latency", cyc, 32'd1);
        chk("n_op_a", {16'd0, op_a}, 32'h3C00);
        chk("n_op_b", {16'd0, op_b}, 32'h4000);
        chk("n_op_code", {30'd0, op_code}, 32'd0);
        chk("n_starts", start_cnt, 32'd1);
        calc_ready = 1'b0;

        // Held button: only the value at the rising edge is captured
        press(16'h0000);
        chk("done_to_a", {29'd0, state}, 32'd0);
        @(negedge clk);
        switches = 16'h1111; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            switches = 16'h2000 + 16'(i);
        end
        enable = 1'b0;
        chk("held_state", {29'd0, state}, 32'd1);
        chk("held_op_a", {16'd0, op_a}, 32'h1111);
        chk("held_op_b", {16'd0, op_b}, 32'h4000);

        // Timeout: calculator never answers
        press(16'h2222);
        press(16'h0003);
        sb.push_back('{res: 16'h0000, fl: 6'd0, to: 1'b1});
        @(negedge clk);
        chk("to_wait", {29'd0, state}, 32'd4);
        wait_done(cyc);
        chk("to_latency", cyc, 32'd64);
        chk("to_op_code", {30'd0, op_code}, 32'd3);

        // Next GO clears timeout; edges during WAIT are ignored; flags pass through
        press(16'h0000);
        press(16'h1234);
        press(16'h5678);
        press(16'h0002);
        chk("to_sticky_in_go", {31'd0, timeout}, 32'd1);
        @(negedge clk);
        chk("to_cleared", {31'd0, timeout}, 32'd0);
        press(16'hFFFF);
        press(16'hFFFF);
        press(16'hFFFF);
        chk("ign_state", {29'd0, state}, 32'd4);
        chk("ign_op_a", {16'd0, op_a}, 32'h1234);
        sb.push_back('{res: 16'h7C00, fl: 6'b101001, to: 1'b0});
        calc_ready = 1'b1; calc_result = 16'h7C00; calc_flags = 6'b101001;
        wait_done(cyc);
        chk("ign_latency", cyc, 32'd1);
        calc_ready = 1'b0;
        press(16'h0000);
        chk("ign_back_to_a", {29'd0, state}, 32'd0);
        chk("ign_starts", start_cnt, 32'd3);

        // Reset during WAIT with enable held through release
        press(16'h0101);
        press(16'h0202);
        press(16'h0001);
        @(negedge clk);
        chk("r_wait", {29'd0, state}, 32'd4);
        enable = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("r_state", {29'd0, state}, 32'd0);
        chk("r_op_a", {16'd0, op_a}, 32'd0);
        chk("r_op_b", {16'd0, op_b}, 32'd0);
        chk("r_op_code", {30'd0, op_code}, 32'd0);
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_result", {16'd0, result}, 32'd0);
        chk("r_flags", {26'd0, flags}, 32'd0);
        chk("r_timeout", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("r_hold_state", {29'd0, state}, 32'd0);
        chk("r_hold_op_a", {16'd0, op_a}, 32'd0);
        enable = 1'b0;
        press(16'hAAAA);
        chk("r_cap_state", {29'd0, state}, 32'd1);
        chk("r_cap_op_a", {16'd0, op_a}, 32'hAAAA);
        chk("r_starts", start_cnt, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
